// File: rtl/fir_datapath_if.sv
// fir_datapath_if -- operation bus between the FIR controller and the datapath.
//
// Signals:
//   op          [2:0]  operation code, one per cycle
//   src1, src2  [3:0]  source register indices
//   dest        [3:0]  destination register index
//   sample_data [15:0] current input sample
//   coeff_data  [15:0] current coefficient value
//   fir_out     [15:0] copy of accumulator R0
//   overflow           combinational flag for the op currently presented
//
// Modports: master = controller side, slave = datapath side.
interface fir_datapath_if;
  logic [2:0]  op;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  dest;
  logic [15:0] sample_data;
  logic [15:0] coeff_data;
  logic [15:0] fir_out;
  logic        overflow;

  modport master (
    output op, src1, src2, dest, sample_data, coeff_data,
    input  fir_out, overflow
  );

  modport slave (
    input  op, src1, src2, dest, sample_data, coeff_data,
    output fir_out, overflow
  );
endinterface

// File: rtl/fir_datapath.sv
// fir_datapath -- 16 x 16-bit register file with a single-cycle ALU
// (copy, load sample, load coefficient, add, subtract, Q1.15 multiply)
// driven one op per cycle by the FIR controller.
//
// Ports:
//   clk    system clock, rising-edge state updates
//   n_rst  asynchronous active-low reset, clears all registers
//   bus    fir_datapath_if.slave: op/src1/src2/dest/sample_data/coeff_data
//          in, fir_out (= R0) and combinational overflow out
//
// Configuration macro: FIR_DATAPATH_SAT_EN
//   undefined: an overflowing op leaves every register unchanged
//   defined:   an overflowing op writes a saturated value
//              (0xFFFF for ADD/MUL, 0x0000 for SUB)
module fir_datapath (
  input  logic      clk,
  input  logic      n_rst,
  fir_datapath_if.slave bus
);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_COPY  = 3'b001,
    OP_LOAD1 = 3'b010,
    OP_LOAD2 = 3'b011,
    OP_ADD   = 3'b100,
    OP_SUB   = 3'b101,
    OP_MUL   = 3'b110,
    OP_RSVD  = 3'b111
  } op_e;

  logic [15:0] regs [16];
  logic [15:0] rs1;
  logic [15:0] rs2;
  logic [16:0] sum;
  logic [16:0] diff;
  logic [31:0] prod;
  logic        unused_prod_lsbs;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        ovf;

  // Both read ports see the pre-edge register contents.
  assign rs1  = regs[bus.src1];
  assign rs2  = regs[bus.src2];
  assign sum  = {1'b0, rs1} + {1'b0, rs2};
  assign diff = {1'b0, rs1} - {1'b0, rs2};
  assign prod = {16'd0, rs1} * {16'd0, rs2};

  // Low product bits fall below the Q1.15 result LSB and are dropped.
  assign unused_prod_lsbs = ^prod[14:0];

  // Op decode: result, write enable and overflow for the op presented now.
  always_comb begin
    wr_en   = 1'b0;
    wr_data = 16'd0;
    ovf     = 1'b0;
    case (op_e'(bus.op))
      OP_COPY: begin
        wr_en   = 1'b1;
        wr_data = rs1;
      end
      OP_LOAD1: begin
        wr_en   = 1'b1;
        wr_data = bus.sample_data;
      end
      OP_LOAD2: begin
        wr_en   = 1'b1;
        wr_data = bus.coeff_data;
      end
      OP_ADD: begin
        ovf     = sum[16];
        wr_en   = 1'b1;
        wr_data = sum[15:0];
        if (sum[16]) begin
`ifdef FIR_DATAPATH_SAT_EN
          wr_data = 16'hFFFF;
`else
          wr_en   = 1'b0;
`endif
        end
      end
      OP_SUB: begin
        // Bit 16 of the 17-bit difference is the borrow (src1 < src2).
        ovf     = diff[16];
        wr_en   = 1'b1;
        wr_data = diff[15:0];
        if (diff[16]) begin
`ifdef FIR_DATAPATH_SAT_EN
          wr_data = 16'h0000;
`else
          wr_en   = 1'b0;
`endif
        end
      end
      OP_MUL: begin
        ovf     = prod[31];
        wr_en   = 1'b1;
        wr_data = prod[30:15];
        if (prod[31]) begin
`ifdef FIR_DATAPATH_SAT_EN
          wr_data = 16'hFFFF;
`else
          wr_en   = 1'b0;
`endif
        end
      end
      default: begin
        wr_en = 1'b0;
      end
    endcase
  end

  // Register file: async clear, single write port.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 16; i++) begin
        regs[i] <= 16'd0;
      end
    end else if (wr_en) begin
      regs[bus.dest] <= wr_data;
    end
  end

  assign bus.fir_out  = regs[0];
  // Forced low in reset regardless of op.
  assign bus.overflow = ovf & n_rst;

endmodule
